// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions: state encodings, datapath widths and the
// arctangent table (also used by the rotation-mode core).
package cordic_pkg;

    localparam int unsigned ITER = 6;   // CORDIC iterations / angle table entries
    localparam int unsigned IW   = 8;   // internal x/y width: 6 data + 2 guard bits
    localparam int unsigned ZW   = 7;   // internal angle accumulator width
    localparam int unsigned DW   = 6;   // operand / result width on the pins

    // Start value of x for the rotation core (1/K in din units).
    localparam logic [IW-1:0] X0 = 8'd19;

    typedef enum logic [1:0] {
        StIdle = 2'd0,  // reset / x sampling; exit edge captures y
        StCalc = 2'd1,
        StDone = 2'd2,
        StGain = 2'd3
    } state_e;

    // atan(2^-i) in units of 180/62 degrees.
    function automatic logic [ZW-1:0] angle_lut(input logic [2:0] idx);
        logic [ZW-1:0] a;
        case (idx)
            3'd0:    a = 7'd16;
            3'd1:    a = 7'd9;
            3'd2:    a = 7'd5;
            3'd3:    a = 7'd2;
            3'd4:    a = 7'd1;
            3'd5:    a = 7'd1;
            default: a = 7'd0;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/cordic_stage_vec.sv
// One vectoring-mode CORDIC iteration: drives y towards zero and
// accumulates the rotated angle in z. Purely combinational.
module cordic_stage_vec
    import cordic_pkg::*;
(
    input  logic signed [IW-1:0] x_i,
    input  logic signed [IW-1:0] y_i,
    input  logic signed [ZW-1:0] z_i,
    input  logic        [2:0]    i_i,
    input  logic signed [ZW-1:0] a_i,
    output logic signed [IW-1:0] x_o,
    output logic signed [IW-1:0] y_o,
    output logic signed [ZW-1:0] z_o
);

    logic signed [IW-1:0] x_sh;
    logic signed [IW-1:0] y_sh;

    // Rotate against the sign of y; both updates use the incoming values.
    always_comb begin
        x_sh = x_i >>> i_i;
        y_sh = y_i >>> i_i;
        if (y_i[IW-1]) begin
            x_o = x_i - y_sh;
            y_o = y_i + x_sh;
            z_o = z_i - a_i;
        end else begin
            x_o = x_i + y_sh;
            y_o = y_i - x_sh;
            z_o = z_i + a_i;
        end
    end

endmodule

// File: rtl/cordic_vectoring_6b.sv
// Iterative 6-bit vectoring CORDIC: (x, y) -> atan(y/x) and magnitude,
// streamed as alternating angle/magnitude words once done.
// Optional macro GAIN_COMP_EN adds one cycle that removes the CORDIC gain
// from the magnitude.
module cordic_vectoring_6b
    import cordic_pkg::*;
(
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic [DW-1:0] din_i,
    output logic          done_o,
    output logic          phase_o,
    output logic [DW-1:0] dout_o
);

    state_e               state_q;
    logic signed [IW-1:0] x_q;
    logic signed [IW-1:0] y_q;
    logic signed [ZW-1:0] z_q;
    logic        [2:0]    i_q;
    logic                 done_q;
    logic                 phase_q;
    logic        [DW-1:0] dout_q;

    logic signed [IW-1:0] din_ext;
    logic signed [IW-1:0] x_s;
    logic signed [IW-1:0] y_s;
    logic signed [ZW-1:0] z_s;
    logic        [DW-1:0] angle_sat;
    logic        [DW-1:0] mag_sat;

    assign din_ext = {{(IW-DW){din_i[DW-1]}}, din_i};

    cordic_stage_vec u_stage (
        .x_i (x_q),
        .y_i (y_q),
        .z_i (z_q),
        .i_i (i_q),
        .a_i (angle_lut(i_q)),
        .x_o (x_s),
        .y_o (y_s),
        .z_o (z_s)
    );

`ifdef GAIN_COMP_EN
    logic signed [IW-1:0] x_gain;

    // x * (1/2 + 1/8 - 1/64) ~= x / K
    always_comb begin
        x_gain = (x_q >>> 1) + (x_q >>> 3) - (x_q >>> 6);
    end
`endif

    // Saturate angle to signed 6 bits and magnitude to unsigned 6 bits.
    always_comb begin
        if (z_q > 7'sd31) begin
            angle_sat = 6'd31;
        end else if (z_q < -7'sd32) begin
            angle_sat = 6'd32;
        end else begin
            angle_sat = z_q[DW-1:0];
        end
        if (x_q[IW-1:DW] != '0) begin
            mag_sat = 6'd63;
        end else begin
            mag_sat = x_q[DW-1:0];
        end
    end

    // FSM, datapath registers and the registered output serializer.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            x_q     <= din_ext;
            y_q     <= '0;
            z_q     <= '0;
            i_q     <= '0;
            done_q  <= 1'b0;
            phase_q <= 1'b0;
            dout_q  <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    // Left half-plane: pre-rotate by 180 degrees.
                    if (x_q[IW-1]) begin
                        x_q <= -x_q;
                        y_q <= -din_ext;
                    end else begin
                        y_q <= din_ext;
                    end
                    i_q     <= '0;
                    state_q <= StCalc;
                end
                StCalc: begin
                    x_q <= x_s;
                    y_q <= y_s;
                    z_q <= z_s;
                    i_q <= i_q + 3'd1;
                    if (i_q == 3'(ITER - 1)) begin
`ifdef GAIN_COMP_EN
                        state_q <= StGain;
`else
                        state_q <= StDone;
`endif
                    end
                end
`ifdef GAIN_COMP_EN
                StGain: begin
                    x_q     <= x_gain;
                    state_q <= StDone;
                end
`endif
                StDone: begin
                    if (!done_q) begin
                        done_q  <= 1'b1;
                        phase_q <= 1'b0;
                        dout_q  <= angle_sat;
                    end else begin
                        phase_q <= ~phase_q;
                        dout_q  <= phase_q ? angle_sat : mag_sat;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign done_o  = done_q;
    assign phase_o = phase_q;
    assign dout_o  = dout_q;

endmodule

// File: tb/tb_cordic_vectoring_6b.sv
// Directed bench for cordic_vectoring_6b with hand-computed results.
module tb_cordic_vectoring_6b;

`ifdef GAIN_COMP_EN
    localparam int LAT   = 8;
    localparam int MAG_1 = 21;
    localparam int MAG_2 = 20;
    localparam int MAG_3 = 30;
`else
    localparam int LAT   = 7;
    localparam int MAG_1 = 35;
    localparam int MAG_2 = 33;
    localparam int MAG_3 = 49;
`endif

    logic       clk;
    logic       reset;
    logic [5:0] din;
    logic       done;
    logic       phase;
    logic [5:0] dout;

    int n_vec = 0;
    int n_err = 0;

    cordic_vectoring_6b dut (
        .clk_i   (clk),
        .reset_i (reset),
        .din_i   (din),
        .done_o  (done),
        .phase_o (phase),
        .dout_o  (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold reset for two edges with x on din; outputs must clear on the first.
    task automatic load_x(input int x);
        reset = 1'b1;
        din   = x[5:0];
        tick();
        check_val("rst_done", int'(done), 0);
        check_val("rst_phase", int'(phase), 0);
        check_val("rst_dout", int'(dout), 0);
        tick();
    endtask

    // Called right after the L edge; checks latency and first two words.
    task automatic expect_run(input string tag, input int ang, input int mag);
        din = 6'h2a;  // must be ignored from here on
        for (int k = 1; k < LAT; k++) begin
            tick();
            check_val({tag, "_busy"}, int'(done), 0);
        end
        tick();
        check_val({tag, "_done0"}, int'(done), 1);
        check_val({tag, "_phase0"}, int'(phase), 0);
        check_val({tag, "_ang"}, int'(dout), ang & 63);
        tick();
        check_val({tag, "_done1"}, int'(done), 1);
        check_val({tag, "_phase1"}, int'(phase), 1);
        check_val({tag, "_mag"}, int'(dout), mag);
    endtask

    task automatic run_vector(input string tag, input int x, input int y,
                              input int ang, input int mag);
        load_x(x);
        reset = 1'b0;
        din   = y[5:0];
        tick();  // L: y capture
        check_val({tag, "_L"}, int'(done), 0);
        expect_run(tag, ang, mag);
    endtask

    initial begin
        reset = 1'b1;
        din   = '0;
        tick();
        tick();
        check_val("reset_done", int'(done), 0);
        check_val("reset_phase", int'(phase), 0);
        check_val("reset_dout", int'(dout), 0);

        run_vector("t1", 20, 0, 0, MAG_1);

        // Stream keeps alternating angle/magnitude while held in DONE.
        for (int k = 0; k < 10; k++) begin
            tick();
            check_val("t5_done", int'(done), 1);
            check_val("t5_phase", int'(phase), k % 2);
            check_val("t5_dout", int'(dout), (k % 2 == 0) ? 0 : MAG_1);
        end

        run_vector("t2", 0, 20, 31, MAG_2);
        run_vector("t3", 20, -20, -16, MAG_3);

        // Abort at L+3 with a one-edge reset pulse, then restart.
        load_x(20);
        reset = 1'b0;
        din   = 6'd0;
        tick();  // L
        din = 6'h2a;
        tick();
        check_val("t4_abort1", int'(done), 0);
        tick();
        check_val("t4_abort2", int'(done), 0);
        reset = 1'b1;
        din   = 6'd20;
        tick();  // L+3: reset edge reloads x
        check_val("t4_abort3", int'(done), 0);
        reset = 1'b0;
        din   = 6'd0;
        tick();  // new L
        check_val("t4_L", int'(done), 0);
        expect_run("t4", 0, MAG_1);

        run_vector("t6", -20, 0, 0, MAG_1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cordic_vectoring_6b.md
# cordic_vectoring_6b

Iterative 6-bit CORDIC in vectoring mode. It is the inverse of our rotation-mode sine/cosine core: it takes a Cartesian pair (x, y) and returns the angle atan(y/x) and the vector magnitude. It sits behind the same 8-in/8-out TinyTapeout pin budget. Operands load over the data pins around reset release, and results leave on the shared output bus as an alternating, flagged angle/magnitude stream.

## Interface
- ITER, 6: CORDIC iterations; the angle table has ITER entries.
- IW, 8: internal x/y width, which is 6 data bits plus 2 guard bits.
- clk  input  1  rising-edge clock; the top-level wrapper drives it from io_in[0].
- reset  input  1  synchronous, active-high; io_in[1].
- din  input  6  signed operand bus; io_in[7:2].
- done  output  1  result valid; io_out[7].
- phase  output  1  result select, 0 = angle, 1 = magnitude; io_out[6].
- dout  output  6  result data; io_out[5:0].

## Operation
- States: IDLE, LOAD_Y, CALC, GAIN (only with the macro), DONE.
- IDLE (reset high):
  - x sign-extends from din to IW bits every cycle, so the last value wins.
  - y = 0, z = 0, i = 0.
- LOAD_Y: the first edge with reset low captures y from din, sign-extended.
  - If x < 0, both x and y are negated at this edge (180° pre-rotation).
  - For x < 0 the angle result therefore describes (−x, −y); this is a documented ambiguity.
- CALC: one iteration per cycle, i = 0 to ITER−1, with shifts arithmetic and all updates using the old values.
  - If y < 0: x −= y>>>i, y += x>>>i, z −= A[i].
  - Otherwise: x += y>>>i, y −= x>>>i, z += A[i].
- Angle table: A = {16, 9, 5, 2, 1, 1}. The unit is 180/62 degrees per LSB.
- z is held at 7 bits internally. At output it saturates to signed 6-bit, −32 to +31.
- Magnitude is x taken as unsigned and saturated to 63.
- DONE:
  - done = 1.
  - phase starts at 0 and toggles every cycle.
  - dout = phase ? magnitude : angle.
  - DONE is held until reset.
- Outputs are all registered. dout is never muxed by clk.

## Timing
- Reset values: done = 0, phase = 0, dout = 0, state = IDLE.
- Let L be the first clk edge with reset low (the y capture edge).
- CALC edges run from L+1 to L+6.
- done rises at L+7, or at L+8 with GAIN_COMP_EN.
- The first done cycle presents the angle (phase = 0); the next presents the magnitude.
- Reset asserted in any state:
  - The block enters IDLE on that edge and done clears the same edge.
  - The partial result is discarded and x sampling resumes.
- A one-cycle reset pulse is legal. It loads x from din on that edge, then starts a new run.
- din is ignored outside IDLE and LOAD_Y.

## Configuration
- GAIN_COMP_EN defined:
  - One extra GAIN cycle computes x' = (x>>>1) + (x>>>3) − (x>>>6), approximately 0.609·x.
  - The magnitude output is then the true |v| in din units.
- GAIN_COMP_EN undefined:
  - There is no GAIN state.
  - The magnitude output is the raw K·|v| (K ≈ 1.647), saturated to 63.
  - Latency is one cycle shorter.

## Structure
- A shared package cordic_pkg holds:
  - state encodings (RESET/IDLE, CALC, DONE, GAIN)
  - ITER and IW
  - the angle-table constants A[0..5], shared with the rotation core
  - the x0 = 19 constant
- One sub-module, cordic_stage_vec: a combinational single-iteration datapath taking x, y, z, i, and the table entry.
- The top level holds the FSM, registers and output serializer. The TinyTapeout wrapper maps io_in/io_out onto the ports.

## Test plan
1. x=20, y=0: done rises at L+7 with angle 0, then magnitude 35. With GAIN_COMP_EN: done at L+8, angle 0, then magnitude 21.
2. x=0, y=20: internal z = 32, so the angle saturates to 31; magnitude 33 (GAIN_COMP_EN: 20).
3. x=20, y=−20: angle −16, magnitude 49 (GAIN_COMP_EN: 30).
4. Reset asserted at L+3, then released with x=20, y=0:
   - done never rises in the aborted run.
   - The new run gives angle 0 exactly 7 cycles after the new L.
5. Hold DONE for 10 cycles: phase alternates 0/1 every cycle starting at 0, dout alternates angle/magnitude, and done stays 1.
6. x=−20, y=0: the load negates both operands, giving angle 0 and magnitude 35 (identical to test 1).
